// File: rtl/util_axis2irq_pkg.sv
// Shared widths and helpers for the AXI-Stream to interrupt decoder.
// Imported by the stream interface, the per-line module and the top.
package util_axis2irq_pkg;

    localparam int CNT_W   = 8;
    localparam int ERR_W   = 16;
    localparam int TDATA_W = 8;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [ERR_W-1:0]   err_t;
    typedef logic [TDATA_W-1:0] tdata_t;

    localparam err_t ERR_MAX = '1;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic err_t sat_inc(input err_t v);
        return (v == ERR_MAX) ? v : v + err_t'(1);
    endfunction

endpackage

// File: rtl/util_axis2irq_if.sv
// Minimal AXI-Stream slave channel carrying an interrupt number per beat.
// There is no TLAST/TKEEP; every beat stands on its own.
interface util_axis2irq_if;
    import util_axis2irq_pkg::*;

    tdata_t tdata;
    logic   tvalid;
    logic   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/util_axis2irq_line.sv
// One interrupt line: either a sticky level cleared by ack, or a pulse that
// is timed by a reloadable down-counter. irq_nxt feeds the shared irq_any flop.
module util_axis2irq_line
    import util_axis2irq_pkg::*;
#(
    parameter int C_PULSE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic ack,
    output logic irq,
    output logic irq_nxt
);

    generate
        if (C_PULSE_CYCLES == 0) begin : g_level
            // A set on the same edge as an ack wins.
            assign irq_nxt = set | (irq & ~ack);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) irq <= 1'b0;
                else        irq <= irq_nxt;
            end
        end else begin : g_pulse
            localparam cnt_t LOAD = cnt_t'(C_PULSE_CYCLES);

            cnt_t cnt_q;
            cnt_t cnt_nxt;
            logic unused_ack;

            assign unused_ack = ack;

            // Re-triggering reloads the counter, so the pulse is extended,
            // never lengthened cumulatively.
            always_comb begin
                cnt_nxt = cnt_q;
                if (set)                cnt_nxt = LOAD;
                else if (cnt_q != '0)   cnt_nxt = cnt_q - cnt_t'(1);
            end

            assign irq_nxt = (cnt_nxt != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    irq   <= 1'b0;
                end else begin
                    cnt_q <= cnt_nxt;
                    irq   <= irq_nxt;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/util_axis2irq.sv
// Decodes interrupt numbers arriving on an always-ready AXI-Stream slave into
// per-number irq lines; out-of-range numbers bump a saturating error counter.
module util_axis2irq
    import util_axis2irq_pkg::*;
#(
    parameter int C_NUM_IRQ      = 8,
    parameter int C_PULSE_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    util_axis2irq_if.slave       s_axis,
    output logic [C_NUM_IRQ-1:0] irq,
    output logic                 irq_any,
    input  logic [C_NUM_IRQ-1:0] irq_ack,
    output logic [ERR_W-1:0]     err_count
);

    localparam logic [TDATA_W:0] NUM_LIM = (TDATA_W+1)'(C_NUM_IRQ);

    logic                 ready_q;
    logic                 accept;
    logic                 in_range;
    logic [C_NUM_IRQ-1:0] set;
    logic [C_NUM_IRQ-1:0] irq_nxt;
    err_t                 err_cnt_q;

    // Ready only drops during reset; it comes up on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign s_axis.tready = ready_q;
    assign accept        = s_axis.tvalid & ready_q;
    assign in_range      = ({1'b0, s_axis.tdata} < NUM_LIM);

    genvar k;
    generate
        for (k = 0; k < C_NUM_IRQ; k++) begin : g_line
            assign set[k] = accept & in_range & (s_axis.tdata == tdata_t'(k));

            util_axis2irq_line #(
                .C_PULSE_CYCLES (C_PULSE_CYCLES)
            ) u_line (
                .clk     (clk),
                .rst_n   (rst_n),
                .set     (set[k]),
                .ack     (irq_ack[k]),
                .irq     (irq[k]),
                .irq_nxt (irq_nxt[k])
            );
        end
    endgenerate

    // Registered from the lines' next state so it moves on the same edge as irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_any <= 1'b0;
        else        irq_any <= |irq_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   err_cnt_q <= '0;
        else if (accept && !in_range) err_cnt_q <= sat_inc(err_cnt_q);
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_util_axis2irq.sv
// Drives a level-mode and a pulse-mode (4 cycle) decoder with identical beats
// and compares both against a cycle-indexed reference model.
module tb_util_axis2irq;
    import util_axis2irq_pkg::*;

    localparam int N = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] ack = '0;
    tdata_t       tdata = '0;
    logic         tvalid = 1'b0;
    logic [N-1:0] irq_l, irq_p;
    logic         any_l, any_p;
    logic [15:0]  err_l, err_p;

    always #5 clk = ~clk;

    util_axis2irq_if bus_l ();
    util_axis2irq_if bus_p ();

    assign bus_l.tdata  = tdata;
    assign bus_l.tvalid = tvalid;
    assign bus_p.tdata  = tdata;
    assign bus_p.tvalid = tvalid;

    util_axis2irq #(.C_NUM_IRQ(N), .C_PULSE_CYCLES(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .s_axis(bus_l), .irq(irq_l),
        .irq_any(any_l), .irq_ack(ack), .err_count(err_l));

    util_axis2irq #(.C_NUM_IRQ(N), .C_PULSE_CYCLES(P)) dut_p (
        .clk(clk), .rst_n(rst_n), .s_axis(bus_p), .irq(irq_p),
        .irq_any(any_p), .irq_ack(ack), .err_count(err_p));

    // Reference model: level bits, pulse expiry edge numbers, ready, errors.
    bit [N-1:0] lvl_m;
    int         until_m [N];
    bit         rdy_m;
    int         err_m;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [N-1:0] pulse_vec();
        logic [N-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k] = (cyc < until_m[k]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] pv;
        pv = pulse_vec();
        chk("irq_level",    32'(irq_l), 32'(lvl_m));
        chk("any_level",    32'(any_l), 32'(|lvl_m));
        chk("irq_pulse",    32'(irq_p), 32'(pv));
        chk("any_pulse",    32'(any_p), 32'(|pv));
        chk("tready_level", 32'(bus_l.tready), 32'(rdy_m));
        chk("tready_pulse", 32'(bus_p.tready), 32'(rdy_m));
        chk("err_level",    32'(err_l), 32'(err_m));
        chk("err_pulse",    32'(err_p), 32'(err_m));
    endtask

    task automatic reset_model();
        rdy_m = 1'b0;
        lvl_m = '0;
        err_m = 0;
        for (int k = 0; k < N; k++) until_m[k] = 0;
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            reset_model();
        end else begin
            acc   = tvalid && rdy_m;
            lvl_m = lvl_m & ~ack;
            if (acc && int'(tdata) < N) begin
                lvl_m[tdata]   = 1'b1;
                until_m[tdata] = cyc + P;
            end
            if (acc && int'(tdata) >= N && err_m < 16'hFFFF) err_m++;
            rdy_m = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic beat(input int d);
        tvalid = 1'b1;
        tdata  = tdata_t'(d);
        tick();
        tvalid = 1'b0;
    endtask

    int hi;

    initial begin
        reset_model();
        #1;
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_all();
        tick();

        // Level set then ack
        beat(3);
        chk("lvl_set3", 32'(irq_l), 32'h08);
        chk("lvl_any3", 32'(any_l), 32'h1);
        ack = 8'h08;
        tick();
        ack = '0;
        chk("lvl_ack3", 32'(irq_l), 32'h00);

        // Coalesce, then set racing ack, then ack of idle line
        beat(5);
        beat(5);
        ack = 8'h20;
        beat(5);
        ack = '0;
        chk("set_wins", 32'(irq_l[5]), 32'h1);
        ack = 8'hDF;
        tick();
        ack = 8'h20;
        tick();
        ack = '0;
        chk("lvl_clear5", 32'(irq_l), 32'h00);

        // Out-of-range numbers
        beat(8);
        beat(200);
        beat(255);
        chk("bad_irq", 32'(irq_l), 32'h00);
        chk("bad_err", 32'(err_l), 32'd3);

        // Single pulse, then a re-triggered pulse
        repeat (6) tick();
        hi = 0;
        beat(1);
        hi += int'(irq_p[1]);
        repeat (6) begin tick(); hi += int'(irq_p[1]); end
        chk("pulse_len4", 32'(hi), 32'd4);
        hi = 0;
        beat(1);
        hi += int'(irq_p[1]);
        tick();
        hi += int'(irq_p[1]);
        beat(1);
        hi += int'(irq_p[1]);
        repeat (6) begin tick(); hi += int'(irq_p[1]); end
        chk("pulse_len6", 32'(hi), 32'd6);

        // Back-to-back distinct beats
        ack = '1;
        tick();
        ack = '0;
        tvalid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            tdata = tdata_t'(d);
            tick();
            chk("b2b_tready", 32'(bus_l.tready), 32'h1);
        end
        tvalid = 1'b0;
        chk("b2b_irq", 32'(irq_l), 32'h07);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tvalid = 1'($urandom_range(0, 1));
            tdata  = ($urandom_range(0, 7) == 0) ? tdata_t'($urandom_range(8, 255))
                                                 : tdata_t'($urandom_range(0, 7));
            ack    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            tick();
        end
        tvalid = 1'b0;
        ack    = '0;

        // Saturation of the error counter
        force dut_l.err_cnt_q = 16'hFFFE;
        force dut_p.err_cnt_q = 16'hFFFE;
        #1;
        release dut_l.err_cnt_q;
        release dut_p.err_cnt_q;
        err_m = 16'hFFFE;
        chk("err_preload", 32'(err_l), 32'hFFFE);
        beat(9);
        beat(77);
        beat(255);
        chk("err_sat", 32'(err_l), 32'hFFFF);

        // Async reset with pending level interrupts
        ack = '1;
        tick();
        ack = '0;
        tvalid = 1'b1;
        for (int d = 0; d < 4; d++) begin
            tdata = tdata_t'(d);
            tick();
        end
        tvalid = 1'b0;
        chk("pend_0f", 32'(irq_l), 32'h0F);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all();
        chk("rst_irq", 32'(irq_l), 32'h00);
        chk("rst_tready", 32'(bus_l.tready), 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        check_all();
        tick();
        chk("rel_tready", 32'(bus_l.tready), 32'h1);
        beat(6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
